// File: rtl/arbiter_control_if.sv
// Handshake bundle between the L1 requesters, the arbiter datapath and port C,
// as seen by the arbiter control FSM.
interface arbiter_control_if;
  logic input_A_read;
  logic input_A_write;
  logic input_B_read;
  logic input_B_write;
  logic input_C_resp;
  logic input_C_resp_delay;
  logic out_A_resp;
  logic out_B_resp;
  logic out_C_read;
  logic out_C_write;
  logic sel_ab_address_mux;
  logic sel_ab_to_c_data_mux;

  // Requester/datapath side drives requests and C responses.
  modport master (
    output input_A_read, input_A_write, input_B_read, input_B_write,
    output input_C_resp, input_C_resp_delay,
    input  out_A_resp, out_B_resp, out_C_read, out_C_write,
    input  sel_ab_address_mux, sel_ab_to_c_data_mux
  );

  // Control FSM side.
  modport slave (
    input  input_A_read, input_A_write, input_B_read, input_B_write,
    input  input_C_resp, input_C_resp_delay,
    output out_A_resp, out_B_resp, out_C_read, out_C_write,
    output sel_ab_address_mux, sel_ab_to_c_data_mux
  );
endinterface

// File: rtl/arbiter_control.sv
// Control FSM for the L1-to-L2 arbiter: picks requester A or B for port C,
// drives the datapath selects and registered C strobes, returns responses.
module arbiter_control #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input logic               clk,
  input logic               reset_n,
  arbiter_control_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B, DONE} state_t;

  state_t state_reg;
  logic   last_grant_reg;   // 0 = A, 1 = B; steers round-robin
  logic   sel_hold_reg;     // select value held outside GRANT states
  logic   c_read_reg;
  logic   c_write_reg;

  logic req_a;
  logic req_b;
  logic pick_b;
  logic granted_read;
  logic granted_write;
  logic kill_strobe;

  always_comb begin
    req_a  = bus.input_A_read | bus.input_A_write;
    req_b  = bus.input_B_read | bus.input_B_write;
    pick_b = req_b & (~req_a | (ROUND_ROBIN & ~last_grant_reg));

    // Write wins when a requester illegally raises both.
    granted_write = ((state_reg == GRANT_A) & bus.input_A_write) |
                    ((state_reg == GRANT_B) & bus.input_B_write);
    granted_read  = ((state_reg == GRANT_A) & bus.input_A_read & ~bus.input_A_write) |
                    ((state_reg == GRANT_B) & bus.input_B_read & ~bus.input_B_write);

    // The delayed response also kills the strobe so a still-held request
    // cannot re-launch a C access during the response cycle.
    kill_strobe = bus.input_C_resp | bus.input_C_resp_delay;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      sel_hold_reg   <= 1'b0;
      c_read_reg     <= 1'b0;
      c_write_reg    <= 1'b0;
    end else begin
      c_read_reg  <= granted_read & ~kill_strobe;
      c_write_reg <= granted_write & ~kill_strobe;
      case (state_reg)
        IDLE: begin
          if (req_a | req_b) begin
            state_reg      <= pick_b ? GRANT_B : GRANT_A;
            last_grant_reg <= pick_b;
            sel_hold_reg   <= pick_b;
          end
        end
        GRANT_A, GRANT_B: begin
          if (bus.input_C_resp_delay) begin
            state_reg <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.out_A_resp  = (state_reg == GRANT_A) & bus.input_C_resp_delay;
  assign bus.out_B_resp  = (state_reg == GRANT_B) & bus.input_C_resp_delay;
  assign bus.out_C_read  = c_read_reg;
  assign bus.out_C_write = c_write_reg;

  // Outside a grant the selects keep the last owner so the datapath
  // address/data registers stay stable while the strobe drains.
  assign bus.sel_ab_address_mux   = (state_reg == GRANT_A) ? 1'b0 :
                                    (state_reg == GRANT_B) ? 1'b1 : sel_hold_reg;
  assign bus.sel_ab_to_c_data_mux = bus.sel_ab_address_mux;

endmodule

// File: tb/tb_arbiter_control.sv
// Bench for arbiter_control: instance 0 round-robin, instance 1 fixed priority,
// checked every cycle against a transaction-level model plus directed literals.
module tb_arbiter_control;

  logic clk;
  logic reset_n;

  logic a_rd[2], a_wr[2], b_rd[2], b_wr[2], cr[2], cd[2];
  logic o_ar[2], o_br[2], o_cr[2], o_cw[2], o_sa[2], o_sd[2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 3;
  int cnt[2];
  bit auto_drop = 0;
  logic s_ar[2], s_br[2];
  int q0[$];
  int q1[$];
  int exp_rr[4] = '{1, 2, 1, 2};

  // Model: owner 0 = nobody, 1 = A, 2 = B; cool marks the wait cycle after a response.
  int   m_owner[2], m_cool[2], m_last[2];
  logic m_hold[2], m_sr[2], m_sw[2];

  arbiter_control_if bus0 ();
  arbiter_control_if bus1 ();

  arbiter_control #(.ROUND_ROBIN(1'b1)) dut_rr (.clk(clk), .reset_n(reset_n), .bus(bus0));
  arbiter_control #(.ROUND_ROBIN(1'b0)) dut_fx (.clk(clk), .reset_n(reset_n), .bus(bus1));

  assign bus0.input_A_read = a_rd[0];  assign bus1.input_A_read = a_rd[1];
  assign bus0.input_A_write = a_wr[0]; assign bus1.input_A_write = a_wr[1];
  assign bus0.input_B_read = b_rd[0];  assign bus1.input_B_read = b_rd[1];
  assign bus0.input_B_write = b_wr[0]; assign bus1.input_B_write = b_wr[1];
  assign bus0.input_C_resp = cr[0];    assign bus1.input_C_resp = cr[1];
  assign bus0.input_C_resp_delay = cd[0]; assign bus1.input_C_resp_delay = cd[1];

  assign o_ar[0] = bus0.out_A_resp;  assign o_ar[1] = bus1.out_A_resp;
  assign o_br[0] = bus0.out_B_resp;  assign o_br[1] = bus1.out_B_resp;
  assign o_cr[0] = bus0.out_C_read;  assign o_cr[1] = bus1.out_C_read;
  assign o_cw[0] = bus0.out_C_write; assign o_cw[1] = bus1.out_C_write;
  assign o_sa[0] = bus0.sel_ab_address_mux;   assign o_sa[1] = bus1.sel_ab_address_mux;
  assign o_sd[0] = bus0.sel_ab_to_c_data_mux; assign o_sd[1] = bus1.sel_ab_to_c_data_mux;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick(int i);
    logic ra, rb;
    ra = a_rd[i] | a_wr[i];
    rb = b_rd[i] | b_wr[i];
    if (ra && rb) return (i == 0 && m_last[i] == 1) ? 2 : 1;
    if (ra) return 1;
    if (rb) return 2;
    return 0;
  endfunction

  function automatic int owner_writes(int i);
    if (m_owner[i] == 1) return int'(a_wr[i]);
    if (m_owner[i] == 2) return int'(b_wr[i]);
    return 0;
  endfunction

  function automatic int owner_reads(int i);
    if (m_owner[i] == 1) return int'(a_rd[i] & ~a_wr[i]);
    if (m_owner[i] == 2) return int'(b_rd[i] & ~b_wr[i]);
    return 0;
  endfunction

  function automatic int exp_sel(int i);
    if (m_owner[i] == 1) return 0;
    if (m_owner[i] == 2) return 1;
    return int'(m_hold[i]);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_owner[i] <= 0; m_cool[i] <= 0; m_last[i] <= 2;
        m_hold[i] <= 1'b0; m_sr[i] <= 1'b0; m_sw[i] <= 1'b0;
      end else begin
        // C access stays open while the owner requests and C has not answered.
        m_sw[i] <= (owner_writes(i) == 1) && !cr[i] && !cd[i];
        m_sr[i] <= (owner_reads(i) == 1) && !cr[i] && !cd[i];
        if (m_cool[i] != 0) begin
          m_cool[i] <= 0;
        end else if (m_owner[i] == 0) begin
          if (pick(i) != 0) begin
            m_owner[i] <= pick(i);
            m_last[i]  <= pick(i);
            m_hold[i]  <= (pick(i) == 2);
          end
        end else if (cd[i]) begin
          m_owner[i] <= 0;
          m_cool[i]  <= 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("a_resp[%0d]", i), o_ar[i], int'(m_owner[i] == 1 && cd[i]));
      chk($sformatf("b_resp[%0d]", i), o_br[i], int'(m_owner[i] == 2 && cd[i]));
      chk($sformatf("c_read[%0d]", i), o_cr[i], m_sr[i]);
      chk($sformatf("c_write[%0d]", i), o_cw[i], m_sw[i]);
      chk($sformatf("sel_addr[%0d]", i), o_sa[i], exp_sel(i));
      chk($sformatf("sel_data[%0d]", i), o_sd[i], exp_sel(i));
      chk($sformatf("one_resp[%0d]", i), o_ar[i] & o_br[i], 0);
      chk($sformatf("one_strobe[%0d]", i), o_cr[i] & o_cw[i], 0);
      s_ar[i] <= o_ar[i];
      s_br[i] <= o_br[i];
      if (o_ar[i] || o_br[i]) begin
        if (i == 0) q0.push_back(o_ar[i] ? 1 : 2);
        else        q1.push_back(o_ar[i] ? 1 : 2);
      end
    end
  end

  // One cycle: port-C responder (resp on the lat-th strobe cycle, delayed copy)
  // and requesters that drop their request after seeing their response.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      cd[i] = cr[i];
      if (cr[i]) begin
        cr[i] = 1'b0;
        cnt[i] = 0;
      end else if (o_cr[i] || o_cw[i]) begin
        cnt[i] = cnt[i] + 1;
        if (cnt[i] >= lat) cr[i] = 1'b1;
      end else begin
        cnt[i] = 0;
      end
      if (auto_drop && s_ar[i]) begin a_rd[i] = 1'b0; a_wr[i] = 1'b0; end
      if (auto_drop && s_br[i]) begin b_rd[i] = 1'b0; b_wr[i] = 1'b0; end
    end
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic look();
    #2;
  endtask

  task automatic req(input logic ar, input logic aw, input logic br, input logic bw);
    for (int i = 0; i < 2; i++) begin
      a_rd[i] = ar; a_wr[i] = aw; b_rd[i] = br; b_wr[i] = bw;
    end
  endtask

  task automatic clear_c();
    for (int i = 0; i < 2; i++) begin
      cr[i] = 1'b0; cd[i] = 1'b0; cnt[i] = 0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req(0, 0, 0, 0);
    clear_c();
    step();
    step();
    reset_n = 1'b1;
    q0.delete();
    q1.delete();
    cyc = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    req(0, 0, 0, 0);
    clear_c();
    step();
    step();
    look();
    chk("rst a_resp", o_ar[0], 0);
    chk("rst b_resp", o_br[0], 0);
    chk("rst c_read", o_cr[0], 0);
    chk("rst c_write", o_cw[0], 0);
    chk("rst sel", o_sa[0] | o_sd[0], 0);

    // Single A read, C responds on the third strobe cycle.
    do_reset(); lat = 3; auto_drop = 1; req(1, 0, 0, 0);
    run_to(1); look(); chk("t1 sel c1", o_sa[0], 0);
    run_to(2); look(); chk("t1 c_read c2", o_cr[0], 1);
    run_to(4); look(); chk("t1 c_read c4", o_cr[0], 1); chk("t1 a_resp c4", o_ar[0], 0);
    run_to(5); look(); chk("t1 c_read c5", o_cr[0], 0); chk("t1 a_resp c5", o_ar[0], 1);
    run_to(6); look(); chk("t1 a_resp c6", o_ar[0], 0);
    run_to(8); look(); chk("t1 c_read c8", o_cr[0], 0);

    // A read and B write raised together: A first, B after the DONE/IDLE gap.
    do_reset(); lat = 3; auto_drop = 1; req(1, 0, 0, 1);
    run_to(5);  look(); chk("t2 a_resp c5", o_ar[0], 1);
    run_to(7);  look(); chk("t2 sel c7", o_sa[0], 0);
    run_to(8);  look(); chk("t2 sel c8", o_sa[0], 1); chk("t2 c_write c8", o_cw[0], 0);
    run_to(9);  look(); chk("t2 c_write c9", o_cw[0], 1); chk("t2 sel_data c9", o_sd[0], 1);
    run_to(12); look(); chk("t2 b_resp c12", o_br[0], 1); chk("t2 b_resp fx c12", o_br[1], 1);
    run_to(13); look(); chk("t2 b_resp c13", o_br[0], 0);

    // Both held continuously: round-robin alternates, fixed priority starves B.
    do_reset(); lat = 2; auto_drop = 0; req(1, 0, 0, 1);
    run_to(23); req(0, 0, 0, 0);
    run_to(28);
    chk("t3 rr count", q0.size(), 4);
    chk("t3 fx count", q1.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3 rr order %0d", k), (k < q0.size()) ? q0[k] : 0, exp_rr[k]);
      chk($sformatf("t3 fx order %0d", k), (k < q1.size()) ? q1[k] : 0, 1);
    end

    // B write, C responds on the second strobe cycle; selects hold B afterwards.
    do_reset(); lat = 2; auto_drop = 1; req(0, 0, 0, 1);
    run_to(1); look(); chk("t4 sel c1", o_sa[0], 1);
    run_to(2); look(); chk("t4 c_write c2", o_cw[0], 1);
    run_to(3); look(); chk("t4 c_write c3", o_cw[0], 1);
    run_to(4); look(); chk("t4 c_write c4", o_cw[0], 0); chk("t4 b_resp c4", o_br[0], 1);
    run_to(6); look(); chk("t4 sel c6", o_sd[0], 1);
    run_to(8); look(); chk("t4 sel c8", o_sa[0], 1); chk("t4 c_write c8", o_cw[0], 0);

    // Async reset in the middle of a B write.
    do_reset(); lat = 20; auto_drop = 1; req(0, 0, 0, 1);
    run_to(3); look(); chk("t5 c_write pre", o_cw[0], 1); chk("t5 sel pre", o_sa[0], 1);
    reset_n = 1'b0;
    #1;
    chk("t5 c_write rst", o_cw[0], 0);
    chk("t5 b_resp rst", o_br[0], 0);
    chk("t5 sel rst", o_sa[0] | o_sd[0], 0);
    clear_c();
    step();
    reset_n = 1'b1; lat = 2; q0.delete(); q1.delete(); cyc = 0;
    req(1, 0, 0, 1);
    run_to(1); look(); chk("t5 sel after", o_sa[0], 0);
    run_to(16);
    chk("t5 count", q0.size(), 2);
    chk("t5 first", (q0.size() > 0) ? q0[0] : 0, 1);
    chk("t5 second", (q0.size() > 1) ? q0[1] : 0, 2);

    // Spurious delayed response while idle.
    run_to(18);
    cd[0] = 1'b1; cd[1] = 1'b1;
    look();
    chk("t6 a_resp", o_ar[0], 0);
    chk("t6 b_resp", o_br[0], 0);
    chk("t6 sel", o_sa[0], 1);
    step(); look();
    chk("t6 strobes", o_cr[0] | o_cw[0], 0);
    chk("t6 sel next", o_sa[0], 1);
    run_to(cyc + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
